// File: rtl/axilite_pkg.sv
// Shared types and helpers for the AXI-Lite register slave.
package axilite_pkg;

    localparam int         RESP_WIDTH  = 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        return res;
    endfunction

endpackage

// File: rtl/axilite_reg_slave.sv
// AXI-Lite responder exposing NUM_REGS 32-bit registers, with independent
// write (AW/W capture, commit, B) and read (AR, R) paths.
module axilite_reg_slave
    import axilite_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [ADDR_WIDTH-1:0]    awaddr,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [31:0]              wdata,
    input  logic [3:0]               wstrb,
    input  logic                     wvalid,
    output logic                     wready,
    output logic [RESP_WIDTH-1:0]    bresp,
    output logic                     bvalid,
    input  logic                     bready,
    input  logic [ADDR_WIDTH-1:0]    araddr,
    input  logic                     arvalid,
    output logic                     arready,
    output logic [31:0]              rdata,
    output logic [RESP_WIDTH-1:0]    rresp,
    output logic                     rvalid,
    input  logic                     rready,
    output logic [32*NUM_REGS-1:0]   reg_q,
    output logic [NUM_REGS-1:0]      reg_wr
);

    localparam int IDX_W = ADDR_WIDTH - 2;

    if (DATA_WIDTH != 32) begin : g_bad_data_width
        $error("axilite_reg_slave: DATA_WIDTH must be 32");
    end
    if (NUM_REGS * 4 > 2 ** ADDR_WIDTH) begin : g_bad_num_regs
        $error("axilite_reg_slave: NUM_REGS does not fit in the address space");
    end

    // Byte-lane bits are dropped: accesses are word-aligned by truncation.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{awaddr[1:0], araddr[1:0]};

    wr_state_t                       wstate_q, wstate_d;
    rd_state_t                       rstate_q, rstate_d;
    logic                            aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [IDX_W-1:0]                widx_q, widx_d;
    logic [31:0]                     wdata_q, wdata_d;
    logic [3:0]                      wstrb_q, wstrb_d;
    logic                            awready_q, awready_d, wready_q, wready_d;
    logic                            bvalid_q, bvalid_d;
    logic [RESP_WIDTH-1:0]           bresp_q, bresp_d;
    logic [NUM_REGS-1:0]             reg_wr_q, reg_wr_d;
    logic [NUM_REGS-1:0][31:0]       regs_q, regs_d;
    logic                            arready_q, arready_d, rvalid_q, rvalid_d;
    logic [31:0]                     rdata_q, rdata_d;
    logic [RESP_WIDTH-1:0]           rresp_q, rresp_d;
    logic [IDX_W-1:0]                ridx;
    logic                            w_mapped, r_mapped;

    assign ridx     = araddr[ADDR_WIDTH-1:2];
    assign w_mapped = int'(widx_q) < NUM_REGS;
    assign r_mapped = int'(ridx) < NUM_REGS;

    always_comb begin
        wstate_d  = wstate_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        widx_d    = widx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        reg_wr_d  = '0;
        regs_d    = regs_q;
        case (wstate_q)
            W_IDLE: begin
                if (awvalid && awready_q) begin
                    aw_held_d = 1'b1;
                    widx_d    = awaddr[ADDR_WIDTH-1:2];
                end
                if (wvalid && wready_q) begin
                    w_held_d = 1'b1;
                    wdata_d  = wdata;
                    wstrb_d  = wstrb;
                end
                // Commit uses the held copies, so the capture above cannot
                // race it: both readies are already low once both are held.
                if (aw_held_q && w_held_q) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (w_mapped && int'(widx_q) == i) begin
                            regs_d[i]   = strb_merge(regs_q[i], wdata_q, wstrb_q);
                            reg_wr_d[i] = 1'b1;
                        end
                    end
                    bresp_d  = w_mapped ? RESP_OKAY : RESP_SLVERR;
                    bvalid_d = 1'b1;
                    wstate_d = W_RESP;
                end
                awready_d = (wstate_d == W_IDLE) && !aw_held_d;
                wready_d  = (wstate_d == W_IDLE) && !w_held_d;
            end
            W_RESP: begin
                awready_d = 1'b0;
                wready_d  = 1'b0;
                if (bready) begin
                    bvalid_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    wstate_d  = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_d  = rstate_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (rstate_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (arvalid && arready_q) begin
                    rdata_d = '0;
                    for (int i = 0; i < NUM_REGS; i++)
                        if (r_mapped && int'(ridx) == i) rdata_d = regs_q[i];
                    rresp_d   = r_mapped ? RESP_OKAY : RESP_SLVERR;
                    rvalid_d  = 1'b1;
                    arready_d = 1'b0;
                    rstate_d  = R_DATA;
                end
            end
            R_DATA: begin
                arready_d = 1'b0;
                if (rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    rstate_d  = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            wstate_q  <= W_IDLE;
            rstate_q  <= R_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            widx_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            reg_wr_q  <= '0;
            regs_q    <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            wstate_q  <= wstate_d;
            rstate_q  <= rstate_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            widx_q    <= widx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            reg_wr_q  <= reg_wr_d;
            regs_q    <= regs_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign reg_wr  = reg_wr_q;
    assign reg_q   = regs_q;

endmodule
